// File: rtl/key_op_sampler.sv
// key_op_sampler: synchronises and debounces the board switches and keys,
// then presents a stable opcode and latched A/B operands to the ALU.
//
// Ports:
//   CLOCK_50  in   1  system clock, rising edge
//   resetn    in   1  asynchronous active-low reset
//   SW        in   8  raw operand switches, [7:4]=A, [3:0]=B
//   KEY       in   3  raw active-low pushbuttons
//   opSelect  out  3  debounced opcode (3'b111 = no key pressed)
//   op_valid  out  1  one-cycle strobe when opSelect/A/B are updated
//   A         out  4  operand A, captured with op_valid
//   B         out  4  operand B, captured with op_valid
//
// Optional feature macro: STICKY_OP_EN
//   defined   : only presses update the outputs; releases are ignored
//   undefined : every debounced key change updates the outputs
module key_op_sampler #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic [7:0] SW,
    input  logic [2:0] KEY,
    output logic [2:0] opSelect,
    output logic       op_valid,
    output logic [3:0] A,
    output logic [3:0] B
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    // Acceptance happens on the edge where the counter already holds
    // DEBOUNCE_CYCLES-1 completed mismatch cycles, so the counter never
    // climbs past its saturation value.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [2:0] KEY_IDLE = 3'b111;

    typedef enum logic {
        STABLE  = 1'b0,
        PENDING = 1'b1
    } deb_state_e;

    // Two-flop synchronisers
    logic [2:0] k_s1;
    logic [2:0] k_s2;
    logic [7:0] sw_s1;
    logic [7:0] sw_s2;

    // Debounce state
    logic [2:0]            deb;
    logic [2:0]            deb_nxt;
    logic [2:0][CNT_W-1:0] cnt;
    logic [2:0][CNT_W-1:0] cnt_nxt;
    deb_state_e [2:0]      state;

    // Update stage
    logic [2:0] deb_prev;
    logic       trig;

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            k_s1  <= KEY_IDLE;
            k_s2  <= KEY_IDLE;
            sw_s1 <= '0;
            sw_s2 <= '0;
        end else begin
            k_s1  <= KEY;
            k_s2  <= k_s1;
            sw_s1 <= SW;
            sw_s2 <= sw_s1;
        end
    end

    // Per-key state is whether the synchronised level disagrees with the
    // accepted level; the counter tracks how long that has persisted.
    always_comb begin
        deb_nxt = deb;
        cnt_nxt = '0;
        state   = '{default: STABLE};
        for (int i = 0; i < 3; i++) begin
            state[i] = (k_s2[i] != deb[i]) ? PENDING : STABLE;
            unique case (state[i])
                STABLE: begin
                    cnt_nxt[i] = '0;
                end
                PENDING: begin
                    if (cnt[i] >= CNT_LAST) begin
                        deb_nxt[i] = k_s2[i];
                        cnt_nxt[i] = '0;
                    end else begin
                        cnt_nxt[i] = cnt[i] + 1'b1;
                    end
                end
                default: begin
                    cnt_nxt[i] = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            deb <= KEY_IDLE;
            cnt <= '0;
        end else begin
            deb <= deb_nxt;
            cnt <= cnt_nxt;
        end
    end

    // deb_prev lags deb by one cycle, so a mismatch marks the cycle right
    // after an acceptance. Several keys accepted together give one change.
`ifdef STICKY_OP_EN
    assign trig = (deb != deb_prev) && (deb != KEY_IDLE);
`else
    assign trig = (deb != deb_prev);
`endif

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            deb_prev <= KEY_IDLE;
            opSelect <= KEY_IDLE;
            op_valid <= 1'b0;
            A        <= '0;
            B        <= '0;
        end else begin
            deb_prev <= deb;
            if (trig) begin
                opSelect <= deb;
                A        <= sw_s2[7:4];
                B        <= sw_s2[3:0];
                op_valid <= 1'b1;
            end else begin
                op_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_key_op_sampler.sv
// tb_key_op_sampler: table-driven and scoreboard checks of key_op_sampler
// with DEBOUNCE_CYCLES=4.
module tb_key_op_sampler;

    logic       clk = 1'b0;
    logic       resetn = 1'b1;
    logic [7:0] sw = 8'h00;
    logic [2:0] key = 3'b111;
    logic [2:0] op_select;
    logic       op_valid;
    logic [3:0] a;
    logic [3:0] b;

    key_op_sampler #(.DEBOUNCE_CYCLES(4)) dut (
        .CLOCK_50(clk),
        .resetn  (resetn),
        .SW      (sw),
        .KEY     (key),
        .opSelect(op_select),
        .op_valid(op_valid),
        .A       (a),
        .B       (b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] op;
        logic [3:0] a;
        logic [3:0] b;
    } exp_t;

    typedef struct {
        logic [7:0] sw;
        logic [2:0] key;
        bit         pulse;
        logic [2:0] op;
        logic [3:0] a;
        logic [3:0] b;
    } vec_t;

    exp_t sb[$];
    int   nvec = 0;
    int   nmis = 0;
    int   cyc = 0;
    int   pulse_cyc = -1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [2:0] op, input logic [3:0] ea,
                        input logic [3:0] eb);
        exp_t e;
        e.op = op;
        e.a  = ea;
        e.b  = eb;
        sb.push_back(e);
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
        chk("missing_pulse", sb.size(), 0);
        sb.delete();
    endtask

    task automatic chk_out(input string name, input logic [2:0] op,
                           input logic [3:0] ea, input logic [3:0] eb);
        chk({name, "_op"}, op_select, op);
        chk({name, "_a"}, a, ea);
        chk({name, "_b"}, b, eb);
    endtask

    // Output monitor: every op_valid pulse must match the oldest
    // outstanding expectation; a pulse with nothing expected is an error.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (resetn && op_valid) begin
                pulse_cyc = cyc;
                if (sb.size() == 0) begin
                    nvec++;
                    nmis++;
                    $display("FAIL unexpected_pulse: got op_valid=1 op=%b want no pulse",
                             op_select);
                end else begin
                    e = sb.pop_front();
                    chk("pulse_op", op_select, e.op);
                    chk("pulse_a", a, e.a);
                    chk("pulse_b", b, e.b);
                end
            end
        end
    end

    vec_t vecs[5];
    logic [2:0] cur_op;
    logic [3:0] cur_a;
    logic [3:0] cur_b;
    int         c0;

    initial begin
        vecs[0] = '{8'h5A, 3'b110, 1'b1, 3'b110, 4'h5, 4'hA};
        vecs[1] = '{8'h3C, 3'b110, 1'b0, 3'b110, 4'h5, 4'hA};
`ifdef STICKY_OP_EN
        vecs[2] = '{8'h3C, 3'b111, 1'b0, 3'b110, 4'h5, 4'hA};
`else
        vecs[2] = '{8'h3C, 3'b111, 1'b1, 3'b111, 4'h3, 4'hC};
`endif
        vecs[3] = '{8'h3C, 3'b100, 1'b1, 3'b100, 4'h3, 4'hC};
`ifdef STICKY_OP_EN
        vecs[4] = '{8'h3C, 3'b111, 1'b0, 3'b100, 4'h3, 4'hC};
`else
        vecs[4] = '{8'h3C, 3'b111, 1'b1, 3'b111, 4'h3, 4'hC};
`endif

        // Reset state, observed before any clock edge
        #1 resetn = 1'b0;
        #2;
        chk_out("reset0", 3'b111, 4'h0, 4'h0);
        chk("reset0_valid", op_valid, 1'b0);
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        settle(4);
        chk_out("idle", 3'b111, 4'h0, 4'h0);

        // Table: press, SW-only change, release, two-key press, release
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            sw  = vecs[i].sw;
            key = vecs[i].key;
            if (vecs[i].pulse)
                push(vecs[i].op, vecs[i].a, vecs[i].b);
            settle(12);
            chk_out($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b);
        end
        cur_op = vecs[4].op;

        // Latency of a clean press: pulse exactly 7 edges after the change
        @(negedge clk);
        sw  = 8'h5A;
        key = 3'b110;
        c0  = cyc;
        push(3'b110, 4'h5, 4'hA);
        settle(12);
        chk("latency", 32'(pulse_cyc - c0), 32'd7);
        key = 3'b111;
`ifdef STICKY_OP_EN
        cur_op = 3'b110;
`else
        push(3'b111, 4'h5, 4'hA);
        cur_op = 3'b111;
`endif
        settle(12);
        chk("after_release_op", op_select, cur_op);

        // Bounce on KEY[0]: toggles every 2 cycles, never accepted
        for (int i = 0; i < 10; i++) begin
            key = (i % 2 == 0) ? 3'b110 : 3'b111;
            repeat (2) @(negedge clk);
        end
        key = 3'b111;
        settle(12);
        chk_out("bounce", cur_op, 4'h5, 4'hA);

        // Keys accepted on consecutive edges: two back-to-back pulses
        key = 3'b110;
        @(negedge clk);
        key = 3'b100;
        push(3'b110, 4'h5, 4'hA);
        push(3'b100, 4'h5, 4'hA);
        c0 = cyc;
        settle(14);
        chk("b2b_last_pulse", 32'(pulse_cyc - c0), 32'd7);
        key = 3'b111;
`ifndef STICKY_OP_EN
        push(3'b111, 4'h5, 4'hA);
`endif
        settle(12);

        // Reset mid-debounce: outputs clear at once, count discarded
        sw  = 8'h3C;
        key = 3'b110;
        repeat (4) @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        chk_out("reset_mid", 3'b111, 4'h0, 4'h0);
        chk("reset_mid_valid", op_valid, 1'b0);
        key = 3'b111;
        @(negedge clk);
        resetn = 1'b1;
        settle(12);
        chk_out("post_reset", 3'b111, 4'h0, 4'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
